// File: rtl/cfg_chain_node_if.sv
// Serial configuration stream bundle between daisy-chained cfg_chain_node tiles.
// Carries the upstream (in) beat stream into a node and the downstream (out) beat stream from it.
interface cfg_chain_node_if #(
    parameter int LANES = 1
);
    // Valid-only stream: a beat transfers in every cycle its valid is high, and
    // start is meaningful only alongside valid. There is no ready, so the
    // receiver must take every beat.
    logic             cfg_in_start;
    logic [LANES-1:0] cfg_bit_in;
    logic             cfg_bit_in_valid;
    logic             cfg_out_start;
    logic [LANES-1:0] cfg_bit_out;
    logic             cfg_bit_out_valid;

    modport master (
        output cfg_in_start, cfg_bit_in, cfg_bit_in_valid,
        input  cfg_out_start, cfg_bit_out, cfg_bit_out_valid
    );

    modport slave (
        input  cfg_in_start, cfg_bit_in, cfg_bit_in_valid,
        output cfg_out_start, cfg_bit_out, cfg_bit_out_valid
    );
endinterface

// File: rtl/cfg_chain_node.sv
// Configuration-chain node: loads the first CFG_BITS of a frame, commits them, forwards the rest.
// Optional even-parity check beat is enabled by defining CFG_PARITY_EN.
module cfg_chain_node #(
    parameter int CFG_BITS = 64,
    parameter int LANES    = 1,
    parameter int ID       = 0
) (
    input  logic                clk,
    input  logic                crst,
    cfg_chain_node_if.slave     cfg,
    output logic [CFG_BITS-1:0] cfg_out,
    output logic                cfg_done,
    output logic                cfg_loaded,
    output logic                cfg_err,
    output logic [1:0]          dbg_state,
    output logic [7:0]          dbg_id
);
    localparam int BEATS = CFG_BITS / LANES;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FWD  = 2'd3
`ifdef CFG_PARITY_EN
        , S_PCHK = 2'd2
`endif
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shadow_nxt;
    logic [CNT_W-1:0]   slot;
    logic               last_beat;
    logic               fwd_first;
    logic [LANES-1:0]   bit_out_q;
    logic               out_valid_q;
    logic               out_start_q;
`ifdef CFG_PARITY_EN
    logic               err_q;
`endif

    // A start beat always lands in slot 0, whatever state the frame was in.
    always_comb begin
        slot       = cfg.cfg_in_start ? '0 : cnt;
        shadow_nxt = shadow;
        for (int i = 0; i < BEATS; i++) begin
            if (slot == CNT_W'(i)) shadow_nxt[i*LANES +: LANES] = cfg.cfg_bit_in;
        end
        last_beat = (slot == CNT_W'(BEATS - 1));
    end

    always_ff @(posedge clk) begin
        if (crst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shadow      <= '0;
            cfg_out     <= '0;
            cfg_done    <= 1'b0;
            cfg_loaded  <= 1'b0;
            fwd_first   <= 1'b0;
            bit_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
`ifdef CFG_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            cfg_done    <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            if (cfg.cfg_bit_in_valid) begin
                if (cfg.cfg_in_start || state == S_LOAD) begin
                    shadow <= shadow_nxt;
                    cnt    <= slot + 1'b1;
`ifdef CFG_PARITY_EN
                    if (cfg.cfg_in_start) err_q <= 1'b0;
`endif
                    if (last_beat) begin
`ifdef CFG_PARITY_EN
                        state <= S_PCHK;
`else
                        cfg_out    <= shadow_nxt;
                        cfg_done   <= 1'b1;
                        cfg_loaded <= 1'b1;
                        fwd_first  <= 1'b1;
                        state      <= S_FWD;
`endif
                    end else begin
                        state <= S_LOAD;
                    end
                end else if (state == S_FWD) begin
                    bit_out_q   <= cfg.cfg_bit_in;
                    out_valid_q <= 1'b1;
                    out_start_q <= fwd_first;
                    fwd_first   <= 1'b0;
                end
`ifdef CFG_PARITY_EN
                // Only lane 0 of the parity beat matters; it is consumed, never forwarded.
                else if (state == S_PCHK) begin
                    if (cfg.cfg_bit_in[0] == ^shadow) begin
                        cfg_out    <= shadow;
                        cfg_done   <= 1'b1;
                        cfg_loaded <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    fwd_first <= 1'b1;
                    state     <= S_FWD;
                end
`endif
            end
        end
    end

    assign cfg.cfg_bit_out       = bit_out_q;
    assign cfg.cfg_bit_out_valid = out_valid_q;
    assign cfg.cfg_out_start     = out_start_q;
`ifdef CFG_PARITY_EN
    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif
    assign dbg_state = state;
    assign dbg_id    = 8'(ID);
endmodule

// File: doc/cfg_chain_node.md
# cfg_chain_node

Parametrised configuration-chain node for fabric tiles. Generalises the per-tile serial config port (start / bit / valid in, start / bit / valid out) to a multi-lane stream. Each node consumes the first CFG_BITS bits of a frame into a shadow register and commits them atomically to its active configuration. It then forwards the remainder of the frame to the next tile with a freshly generated start marker. One instance sits in every CLB/IO tile, and nodes are daisy-chained across the fabric.

## Interface
Parameters:
- CFG_BITS, 64, configuration bits owned by this node; must be a multiple of LANES.
- LANES, 1, bits transferred per beat (1, 2, 4, 8).
- ID, 0, tile identifier; informational only, no behavioural effect.

Ports:
- clk  in  1  single clock for config and fabric logic.
- crst  in  1  reset, synchronous, active-high.
- cfg_in_start  in  1  marks the first beat of a frame; qualified by cfg_bit_in_valid.
- cfg_bit_in  in  LANES  incoming config beat.
- cfg_bit_in_valid  in  1  beat valid.
- cfg_out_start  out  1  first forwarded beat marker.
- cfg_bit_out  out  LANES  forwarded beat.
- cfg_bit_out_valid  out  1  forwarded beat valid.
- cfg_out  out  CFG_BITS  active configuration driven to tile logic.
- cfg_done  out  1  one-cycle pulse when cfg_out is updated.
- cfg_loaded  out  1  level; set by the first successful commit, cleared only by crst.
- cfg_err  out  1  sticky parity error; present only with CFG_PARITY_EN, otherwise tied 0.

## Operation
- BEATS = CFG_BITS/LANES. Beat k, 0-based from the start beat, maps to shadow[k*LANES +: LANES].
- A beat is accepted in any cycle with cfg_bit_in_valid=1. cfg_in_start without valid is ignored.
- States: IDLE, LOAD, PCHK (parity builds only), FWD.
- IDLE: a start beat is captured as beat 0, the beat counter is set to 1, and the state moves to LOAD. Non-start beats are dropped.
- LOAD: each accepted beat is captured. After beat BEATS-1 the state moves to PCHK if parity is enabled, otherwise it commits and moves to FWD.
- Commit: cfg_out <= shadow, cfg_done pulses, cfg_loaded <= 1.
- FWD: each accepted beat is forwarded unchanged. The first forwarded beat after entering FWD carries cfg_out_start=1; later beats carry 0.
- Start beat in LOAD, PCHK or FWD: the frame is aborted. The beat is captured as beat 0, the counter is set to 1, and the state moves to LOAD. The shadow is discarded, cfg_out is unchanged, and the beat is not forwarded.
- BEATS=1: a start beat commits immediately, or goes to PCHK in parity builds.
- Invalid cycles (gaps) are allowed anywhere. The state and counter hold during gaps.
- No backpressure. The downstream node must accept every beat.

## Timing
- Reset values: cfg_out=0, cfg_bit_out=0, cfg_bit_out_valid=0, cfg_out_start=0, cfg_done=0, cfg_loaded=0, cfg_err=0. The FSM enters IDLE and the counter is 0.
- crst mid-frame: the partial shadow is discarded and all outputs take their reset values on the next edge.
- Forward latency: 1 cycle. Beat accepted at edge N appears on cfg_bit_out/valid/start after edge N+1. All outputs are registered.
- Commit latency: cfg_out and cfg_done change at the edge after the final beat (or parity beat) is accepted.
- A beat arriving in the cycle immediately after the final load beat is already in FWD and is forwarded as the start beat.

## Configuration
- CFG_PARITY_EN defined: after the BEATS data beats, LOAD moves to PCHK and the next accepted beat is the parity beat.
  - Only cfg_bit_in[0] is checked; the other lanes are ignored. The expected value is the XOR of all CFG_BITS shadow bits (even parity).
  - Match: commit, then FWD.
  - Mismatch: no commit, cfg_done stays 0, cfg_err <= 1, then FWD. Forwarding is unaffected.
  - cfg_err clears on crst or on the next accepted start beat.
  - The parity beat is never forwarded.
- CFG_PARITY_EN undefined: no PCHK state, no parity beat is expected, and cfg_err is constant 0.

## Test plan
Use CFG_BITS=8 and LANES=2 unless noted.
- Basic load: start beat 2'b01, then 2'b10, 2'b11, 2'b00, back-to-back -> cfg_out=8'h39 one cycle after the 4th beat, cfg_done pulses once, cfg_loaded=1, cfg_bit_out_valid stays 0.
- Forwarding: same frame plus beats 2'b11, 2'b01 -> cfg_bit_out shows 2'b11 with start=1, then 2'b01 with start=0, each 1 cycle after input.
- Gaps: same 4 load beats, each separated by 3 invalid cycles -> identical cfg_out=8'h39. A start asserted during an invalid cycle is ignored.
- Abort: 2 beats, then a new start frame 2'b11×4 -> cfg_out=8'hFF. No beat is forwarded, and only one cfg_done pulse occurs.
- Reset mid-frame: crst after 2 of 4 beats, then a full frame 2'b10×4 -> cfg_out=8'hAA. All outputs are 0 during and after the reset cycle until the commit.
- Parity (CFG_PARITY_EN): frame 8'h39 plus parity beat bit0=0 -> commit. A second frame of 8'h39 with bit0=1 -> cfg_out holds the prior value, cfg_err=1, and the next forwarded beat still carries start=1.
